// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder: byte-lane stores, extended loads with fixed latency
module dmem_responder #(
  parameter int AW_WORDS = 10,
  parameter int READ_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_read_en,
  input  logic        i_write_en,
  input  logic [31:0] i_addr,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_read_vd,
  output logic        o_misalign,
  output logic        o_busy
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  localparam logic [3:0] LAT_M1 = 4'(READ_LAT - 1);

  state_t state, next_state;

  logic [31:0]         mem [0:(2**AW_WORDS)-1];
  logic [3:0]          cnt;
  logic [AW_WORDS-1:0] cap_idx;
  logic [1:0]          cap_lo;
  logic [2:0]          cap_funct3;
  logic                misalign_q;

  logic                accept_load;
  logic                accept_store;
  logic                store_bad;
  logic                do_store;
  logic                set_misalign;
  logic                cap_bad;
  logic [3:0]          byte_en;
  logic [31:0]         wdata_aligned;
  logic [AW_WORDS-1:0] ld_idx;
  logic [1:0]          ld_lo;
  logic [2:0]          ld_funct3;
  logic [31:0]         ld_word;
  logic [7:0]          ld_byte;
  logic [15:0]         ld_half;
  logic [31:0]         ld_value;

  // High address bits alias onto the array and are deliberately dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = &{1'b0, i_addr[31:AW_WORDS+2]};

  // An access is rejected for an unknown width code or a lane offset the width cannot start at.
  function automatic logic access_bad(input logic [2:0] f3, input logic [1:0] lo);
    logic bad;
    case (f3)
      3'b000, 3'b100: bad = 1'b0;
      3'b001, 3'b101: bad = lo[0];
      3'b010:         bad = (lo != 2'b00);
      default:        bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Request classification in IDLE; a load always wins over a concurrent store.
  always_comb begin
    accept_load  = (state == S_IDLE) && i_read_en;
    accept_store = (state == S_IDLE) && i_write_en && !i_read_en;
    store_bad    = access_bad(i_funct3, i_addr[1:0]);
    do_store     = accept_store && !store_bad;
    set_misalign = (accept_store && store_bad) || ((state == S_IDLE) && i_read_en && i_write_en);
    cap_bad      = access_bad(cap_funct3, cap_lo);
  end

  // Store lane enables and right-aligned data shifted into its byte lanes.
  always_comb begin
    byte_en       = 4'b0000;
    wdata_aligned = i_wdata;
    case (i_funct3[1:0])
      2'b00: begin
        byte_en       = 4'b0001 << i_addr[1:0];
        wdata_aligned = {4{i_wdata[7:0]}};
      end
      2'b01: begin
        byte_en       = i_addr[1] ? 4'b1100 : 4'b0011;
        wdata_aligned = {2{i_wdata[15:0]}};
      end
      default: begin
        byte_en       = 4'b1111;
        wdata_aligned = i_wdata;
      end
    endcase
  end

  // Load path: the live request when entering DONE straight from IDLE, otherwise the captured one.
  always_comb begin
    ld_idx    = (state == S_IDLE) ? i_addr[AW_WORDS+1:2] : cap_idx;
    ld_lo     = (state == S_IDLE) ? i_addr[1:0] : cap_lo;
    ld_funct3 = (state == S_IDLE) ? i_funct3 : cap_funct3;
    ld_word   = mem[ld_idx];
    ld_byte   = ld_word[8*ld_lo +: 8];
    ld_half   = ld_lo[1] ? ld_word[31:16] : ld_word[15:0];
    case (ld_funct3)
      3'b000:  ld_value = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_value = {24'h000000, ld_byte};
      3'b001:  ld_value = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_value = {16'h0000, ld_half};
      3'b010:  ld_value = ld_word;
      default: ld_value = 32'h0000_0000;
    endcase
    if (access_bad(ld_funct3, ld_lo)) begin
      ld_value = 32'h0000_0000;
    end
  end

  // Word array: byte-lane writes, never reset.
  always_ff @(posedge clk) begin
    if (!rst && do_store) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) begin
          mem[i_addr[AW_WORDS+1:2]][8*b +: 8] <= wdata_aligned[8*b +: 8];
        end
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (i_read_en) next_state = (READ_LAT == 1) ? S_DONE : S_WAIT;
      S_WAIT: if (cnt == 4'd1) next_state = S_DONE;
      S_DONE: next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // FSM outputs; a rejected load reports misalignment alongside its data-valid pulse.
  always_comb begin
    o_read_vd  = (state == S_DONE);
    o_busy     = (state != S_IDLE);
    o_misalign = misalign_q || ((state == S_DONE) && cap_bad);
  end

  // Request capture, latency counter, registered load data and store-reject pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= 4'd0;
      cap_idx    <= '0;
      cap_lo     <= 2'b00;
      cap_funct3 <= 3'b000;
      o_rdata    <= 32'h0000_0000;
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= set_misalign;
      if (accept_load) begin
        cap_idx    <= i_addr[AW_WORDS+1:2];
        cap_lo     <= i_addr[1:0];
        cap_funct3 <= i_funct3;
        cnt        <= LAT_M1;
      end else if (state == S_WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (next_state == S_DONE) begin
        o_rdata <= ld_value;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder at read latencies 1, 2 and 4
module tb_dmem_responder;

  typedef struct {
    int          k;
    logic [31:0] d;
    logic        m;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        rd_en [3];
  logic        wr_en [3];
  logic [31:0] addr  [3];
  logic [2:0]  f3    [3];
  logic [31:0] wdata [3];
  logic [31:0] rdata [3];
  logic        vd    [3];
  logic        mis   [3];
  logic        busy  [3];

  int lat_of [3] = '{1, 2, 4};

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_responder #(
      .AW_WORDS(10),
      .READ_LAT((g == 0) ? 1 : ((g == 1) ? 2 : 4))
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .i_read_en (rd_en[g]),
      .i_write_en(wr_en[g]),
      .i_addr    (addr[g]),
      .i_funct3  (f3[g]),
      .i_wdata   (wdata[g]),
      .o_rdata   (rdata[g]),
      .o_read_vd (vd[g]),
      .o_misalign(mis[g]),
      .o_busy    (busy[g])
    );
  end

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];
  exp_t mon_e;
  bit   prev_vd [3] = '{0, 0, 0};
  logic [31:0] mdl [3][1024];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic mdl_bad(input logic [2:0] f, input logic [1:0] lo);
    if (f == 3'b010) return lo != 2'b00;
    if (f == 3'b001 || f == 3'b101) return lo[0];
    if (f == 3'b000 || f == 3'b100) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] mdl_load(input int k, input logic [31:0] a, input logic [2:0] f);
    logic [31:0] w;
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    w  = mdl[k][a[11:2]];
    sh = w >> (8 * a[1:0]);
    b  = sh[7:0];
    h  = a[1] ? w[31:16] : w[15:0];
    if (mdl_bad(f, a[1:0])) return 32'h0;
    case (f)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'h0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'h0, h};
      default: return w;
    endcase
  endfunction

  task automatic mdl_store(input int k, input logic [31:0] a, input logic [2:0] f, input logic [31:0] d);
    case (f[1:0])
      2'b00:   mdl[k][a[11:2]][8*a[1:0] +: 8]  = d[7:0];
      2'b01:   mdl[k][a[11:2]][16*a[1] +: 16] = d[15:0];
      default: mdl[k][a[11:2]]                = d;
    endcase
  endtask

  task automatic do_store(input int k, input logic [31:0] a, input logic [2:0] f, input logic [31:0] d);
    bit bad;
    bad = mdl_bad(f, a[1:0]);
    wr_en[k] = 1'b1; addr[k] = a; f3[k] = f; wdata[k] = d;
    if (!bad) mdl_store(k, a, f, d);
    @(negedge clk);
    wr_en[k] = 1'b0;
    chk("store_misalign", mis[k], bad);
    chk("store_no_vd", vd[k], 0);
  endtask

  task automatic do_load(input int k, input logic [31:0] a, input logic [2:0] f, input bit b2b,
                         input bit hold, input bit with_store, input logic [31:0] sd);
    exp_t e;
    bit   seen;
    int   waited;
    rd_en[k] = 1'b1; addr[k] = a; f3[k] = f;
    if (with_store) begin
      wr_en[k] = 1'b1; wdata[k] = sd;
    end
    e.k = k; e.d = mdl_load(k, a, f); e.m = mdl_bad(f, a[1:0]);
    sb.push_back(e);
    seen = 0; waited = 0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(negedge clk);
      waited = i;
      if (with_store && i == 1) begin
        chk("simul_misalign", mis[k], 1);
        wr_en[k] = 1'b0;
      end
      chk("busy", busy[k], (b2b && i == 1) ? 32'd0 : 32'd1);
      if (vd[k]) seen = 1;
    end
    chk("vd_seen", seen, 1);
    chk("latency", waited, lat_of[k] + (b2b ? 1 : 0));
    if (!hold) begin
      rd_en[k] = 1'b0;
      @(negedge clk);
      chk("rdata_hold", rdata[k], e.d);
      chk("busy_after", busy[k], 0);
      chk("vd_pulse_len", vd[k], 0);
    end
  endtask

  // Response monitor: every valid pulse must match the oldest expected load.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (vd[k]) begin
        chk("vd_gap", prev_vd[k], 0);
        chk("vd_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          chk("sb_inst", k, mon_e.k);
          chk("sb_rdata", rdata[k], mon_e.d);
          chk("sb_misalign", mis[k], mon_e.m);
        end
      end
      prev_vd[k] = vd[k];
    end
  end

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      rd_en[k] = 0; wr_en[k] = 0; addr[k] = 0; f3[k] = 0; wdata[k] = 0;
      for (int w = 0; w < 1024; w++) mdl[k][w] = 32'h0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_rdata", rdata[k], 0);
      chk("rst_vd", vd[k], 0);
      chk("rst_misalign", mis[k], 0);
      chk("rst_busy", busy[k], 0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Latency 2: word, byte and halfword lanes with read-after-write.
    do_store(1, 32'h100, 3'b010, 32'hDEADBEEF);
    do_load (1, 32'h100, 3'b010, 0, 0, 0, 0);
    chk("plan_lw1", rdata[1], 32'hDEADBEEF);
    do_store(1, 32'h101, 3'b000, 32'h00000080);
    do_load (1, 32'h101, 3'b000, 0, 0, 0, 0);
    chk("plan_lb", rdata[1], 32'hFFFFFF80);
    do_load (1, 32'h101, 3'b100, 0, 0, 0, 0);
    do_load (1, 32'h100, 3'b010, 0, 0, 0, 0);
    chk("plan_lw2", rdata[1], 32'hDEAD80EF);
    do_store(1, 32'h102, 3'b001, 32'hFFFF1234);
    do_load (1, 32'h102, 3'b001, 0, 0, 0, 0);
    do_load (1, 32'h100, 3'b101, 0, 0, 0, 0);
    chk("plan_lhu", rdata[1], 32'h000080EF);
    do_load (1, 32'h103, 3'b001, 0, 0, 0, 0);
    do_load (1, 32'h100, 3'b011, 0, 0, 0, 0);
    do_store(1, 32'h102, 3'b010, 32'h01020304);
    do_store(1, 32'h100, 3'b111, 32'h01020304);
    do_load (1, 32'h1100, 3'b010, 0, 0, 0, 0);
    chk("alias_lw", rdata[1], 32'h123480EF);
    do_store(1, 32'h200, 3'b010, 32'h11223344);
    do_load (1, 32'h200, 3'b010, 0, 0, 1, 32'h5555AAAA);
    do_load (1, 32'h200, 3'b010, 0, 0, 0, 0);
    chk("simul_old", rdata[1], 32'h11223344);

    // Latency 1: back-to-back loads with the request held high.
    do_store(0, 32'h010, 3'b010, 32'hA5A5_5A5A);
    do_store(0, 32'h014, 3'b010, 32'h0BAD_F00D);
    do_load (0, 32'h010, 3'b010, 0, 1, 0, 0);
    do_load (0, 32'h014, 3'b010, 1, 1, 0, 0);
    do_load (0, 32'h013, 3'b000, 1, 0, 0, 0);

    // Latency 4: reset aborts an in-flight load, array survives.
    do_store(2, 32'h040, 3'b010, 32'hCAFEF00D);
    do_load (2, 32'h040, 3'b010, 0, 0, 0, 0);
    do_load (2, 32'h042, 3'b001, 0, 0, 0, 0);
    rd_en[2] = 1'b1; addr[2] = 32'h040; f3[2] = 3'b010;
    @(negedge clk);
    chk("abort_busy", busy[2], 1);
    @(negedge clk);
    rst = 1'b1; rd_en[2] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_vd", vd[2], 0);
    chk("abort_rdata", rdata[2], 0);
    chk("abort_busy_clr", busy[2], 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_no_vd", vd[2], 0);
    end
    do_load (2, 32'h040, 3'b010, 0, 0, 0, 0);
    chk("abort_keep", rdata[2], 32'hCAFEF00D);

    repeat (4) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
